// File: rtl/la_scanctrl_pkg.sv
// Shared types and helpers for the scan-chain sequencer.
package la_scanctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StCapt,
    StUnload,
    StDone
  } scan_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/la_scanctrl_sreg.sv
// Right-shifting register with synchronous clear, parallel load and serial input at the MSB.
module la_scanctrl_sreg #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic [Width-1:0] data_i,
  input  logic             shift_i,
  input  logic             sin_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] q_q;
  logic [Width-1:0] shifted;

  // A one-bit register simply takes the serial input on a shift.
  if (Width > 1) begin : g_wide
    assign shifted = {sin_i, q_q[Width-1:1]};
  end else begin : g_narrow
    assign shifted = sin_i;
  end

  // Clear has priority over load, load over shift.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      q_q <= '0;
    end else if (load_i) begin
      q_q <= data_i;
    end else if (shift_i) begin
      q_q <= shifted;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/la_scanctrl.sv
// Scan-chain sequencer: serial load, capture cycles with se low, serial unload into result.
module la_scanctrl
  import la_scanctrl_pkg::*;
#(
  parameter int unsigned N    = 8,
  parameter int unsigned CAPT = 1,
  parameter string       PROP = "DEFAULT"
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] pattern,
  input  logic         so,
  output logic         se,
  output logic         si,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result
);

  localparam int unsigned    CntW      = $clog2(max_u(N, CAPT) + 1);
  localparam logic [CntW-1:0] LoadLast = CntW'(N - 1);
  localparam logic [CntW-1:0] CaptLast = CntW'(CAPT - 1);
  localparam bit             PropEmpty = (PROP == "");

  scan_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            se_q, se_d;
  logic [N-1:0]    result_q;
  logic [N-1:0]    pat_q;
  logic [N-1:0]    res_q;
  logic            pat_load;

  // pat shifts out LSB first with zero fill, so its LSB is a registered si that is already
  // zero once LOAD completes; the upper bits are only consumed through the shift.
  la_scanctrl_sreg #(
    .Width(N)
  ) u_pat (
    .clk_i  (clk),
    .reset_i(reset),
    .load_i (pat_load),
    .data_i (pattern),
    .shift_i(state_q == StLoad),
    .sin_i  (1'b0),
    .q_o    (pat_q)
  );

  // res collects so on every UNLOAD edge; first bit out ends in res[0].
  la_scanctrl_sreg #(
    .Width(N)
  ) u_res (
    .clk_i  (clk),
    .reset_i(reset),
    .load_i (1'b0),
    .data_i ('0),
    .shift_i(state_q == StUnload),
    .sin_i  (so),
    .q_o    (res_q)
  );

  logic unused_sig;
  assign unused_sig = ^{pat_q[N-1:0], PropEmpty};

  // Next state, phase counter and registered scan enable.
  always_comb begin
    state_d  = state_q;
    pat_load = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StLoad;
          pat_load = 1'b1;
        end
      end
      StLoad:   if (cnt_q == LoadLast) state_d = StCapt;
      StCapt:   if (cnt_q == CaptLast) state_d = StUnload;
      StUnload: if (cnt_q == LoadLast) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    cnt_d = '0;
    if ((state_d == state_q) && (state_q != StIdle) && (state_q != StDone)) begin
      cnt_d = cnt_q + 1'b1;
    end

    // se is computed from the next state so it is high exactly during LOAD/UNLOAD cycles.
    se_d = (state_d == StLoad) || (state_d == StUnload);
  end

  // State, counter, scan enable and held result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      se_q     <= 1'b0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      se_q    <= se_d;
      if (state_q == StDone) begin
        result_q <= res_q;
      end
    end
  end

  assign se     = se_q;
  assign si     = pat_q[0];
  assign busy   = (state_q == StLoad) || (state_q == StCapt) || (state_q == StUnload);
  assign done   = (state_q == StDone);
  // res is already complete in DONE; result_q keeps it afterwards.
  assign result = (state_q == StDone) ? res_q : result_q;

endmodule

// File: tb/tb_la_scanctrl.sv
// Bench for la_scanctrl: three instances (N=8/CAPT=1, N=8/CAPT=3, N=1/CAPT=1), each driving a
// behavioural scan chain. Expected results go to a scoreboard queue when a start is scheduled.
module tb_la_scanctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] pattern = '0;
  int         sel = 0;
  logic       dmode = 1'b0;
  logic [7:0] dconst = '0;

  int errors = 0;
  int checks = 0;

  // Instance A: N=8, CAPT=1, loopback or constant capture data.
  logic       start_a, se_a, si_a, busy_a, done_a;
  logic [7:0] result_a, d_a;
  logic [7:0] chain_a = '0;
  assign start_a = start && (sel == 0);
  assign d_a     = dmode ? dconst : chain_a;
  always @(posedge clk) chain_a <= se_a ? {chain_a[6:0], si_a} : d_a;

  la_scanctrl #(.N(8), .CAPT(1)) u_a (
    .clk(clk), .reset(reset), .start(start_a), .pattern(pattern), .so(chain_a[7]),
    .se(se_a), .si(si_a), .busy(busy_a), .done(done_a), .result(result_a)
  );

  // Instance B: N=8, CAPT=3, loopback.
  logic       start_b, se_b, si_b, busy_b, done_b;
  logic [7:0] result_b;
  logic [7:0] chain_b = '0;
  assign start_b = start && (sel == 1);
  always @(posedge clk) chain_b <= se_b ? {chain_b[6:0], si_b} : chain_b;

  la_scanctrl #(.N(8), .CAPT(3)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .pattern(pattern), .so(chain_b[7]),
    .se(se_b), .si(si_b), .busy(busy_b), .done(done_b), .result(result_b)
  );

  // Instance C: N=1, CAPT=1, loopback.
  logic start_c, se_c, si_c, busy_c, done_c, result_c;
  logic chain_c = 1'b0;
  assign start_c = start && (sel == 2);
  always @(posedge clk) chain_c <= se_c ? si_c : chain_c;

  la_scanctrl #(.N(1), .CAPT(1)) u_c (
    .clk(clk), .reset(reset), .start(start_c), .pattern(pattern[0]), .so(chain_c),
    .se(se_c), .si(si_c), .busy(busy_c), .done(done_c), .result(result_c)
  );

  logic       obs_se, obs_si, obs_busy, obs_done;
  logic [7:0] obs_result;
  assign obs_se     = (sel == 0) ? se_a : (sel == 1) ? se_b : se_c;
  assign obs_si     = (sel == 0) ? si_a : (sel == 1) ? si_b : si_c;
  assign obs_busy   = (sel == 0) ? busy_a : (sel == 1) ? busy_b : busy_c;
  assign obs_done   = (sel == 0) ? done_a : (sel == 1) ? done_b : done_c;
  assign obs_result = (sel == 0) ? result_a : (sel == 1) ? result_b : {7'b0, result_c};

  // Scoreboard and per-window traces.
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  int          done_cyc_q[$];
  int          st_cyc[$];
  logic [7:0]  st_pat[$];
  int          rst_cyc = -1;
  logic [63:0] se_tr, si_tr, busy_tr;
  logic [7:0]  res_tr [64];

  function automatic logic [63:0] se_mask(input int n, input int capt);
    logic [63:0] m = '0;
    for (int k = 1; k <= n; k++) m[k] = 1'b1;
    for (int k = n + capt + 1; k <= 2 * n + capt; k++) m[k] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] busy_mask(input int n, input int capt);
    logic [63:0] m = '0;
    for (int k = 1; k <= 2 * n + capt; k++) m[k] = 1'b1;
    return m;
  endfunction

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7 - i];
    return r;
  endfunction

  // Cycle k is the period ending at edge Ek; a start driven in cycle 0 is accepted at E0.
  task automatic run_window(input int lim);
    se_tr = '0; si_tr = '0; busy_tr = '0;
    got_q.delete();
    done_cyc_q.delete();
    @(posedge clk);
    for (int k = 0; k <= lim; k++) begin
      #1;
      start = 1'b0;
      reset = (k == rst_cyc);
      foreach (st_cyc[i]) begin
        if (st_cyc[i] == k) begin
          start   = 1'b1;
          pattern = st_pat[i];
        end
      end
      @(negedge clk);
      se_tr[k]   = obs_se;
      si_tr[k]   = obs_si;
      busy_tr[k] = obs_busy;
      res_tr[k]  = obs_result;
      if (obs_done === 1'b1) begin
        got_q.push_back(obs_result);
        done_cyc_q.push_back(k);
      end
      @(posedge clk);
    end
    #1;
    start   = 1'b0;
    reset   = 1'b0;
    rst_cyc = -1;
    st_cyc.delete();
    st_pat.delete();
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1 reset = 1'b1; start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({se_a, si_a, busy_a, done_a, se_b, si_b, busy_b, done_b, se_c, si_c, busy_c, done_c}
        !== 12'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 0", {se_a, si_a, busy_a, done_a, se_b, si_b,
               busy_b, done_b, se_c, si_c, busy_c, done_c});
    end
    checks++;
    if ({result_a, result_b, result_c} !== 17'b0) begin
      errors++;
      $display("FAIL reset_result: got %h want 0", {result_a, result_b, result_c});
    end
  endtask

  task automatic test_loopback();
    logic [7:0] e, g;
    sel = 0; dmode = 1'b0;
    exp_q.push_back(8'hA5);
    st_cyc.push_back(0); st_pat.push_back(8'hA5);
    run_window(24);
    checks++;
    if (done_cyc_q.size() != 1) begin
      errors++;
      $display("FAIL loopback_done_count: got %0d want 1", done_cyc_q.size());
    end
    checks++;
    if (done_cyc_q.size() == 0 || done_cyc_q[0] != 18) begin
      errors++;
      $display("FAIL loopback_done_cycle: got %0d want 18",
               (done_cyc_q.size() == 0) ? -1 : done_cyc_q[0]);
    end
    e = exp_q.pop_front();
    checks++;
    if (got_q.size() == 0) begin
      errors++;
      $display("FAIL loopback_result: no done seen, want %h", e);
    end else begin
      g = got_q.pop_front();
      if (g !== e) begin
        errors++;
        $display("FAIL loopback_result: got %h want %h", g, e);
      end
    end
    checks++;
    if (se_tr[24:0] !== se_mask(8, 1)[24:0]) begin
      errors++;
      $display("FAIL loopback_se: got %b want %b", se_tr[24:0], se_mask(8, 1)[24:0]);
    end
    checks++;
    if (si_tr[24:0] !== {16'b0, 8'hA5, 1'b0}) begin
      errors++;
      $display("FAIL loopback_si: got %b want %b", si_tr[24:0], {16'b0, 8'hA5, 1'b0});
    end
    checks++;
    if (busy_tr[24:0] !== busy_mask(8, 1)[24:0]) begin
      errors++;
      $display("FAIL loopback_busy: got %b want %b", busy_tr[24:0], busy_mask(8, 1)[24:0]);
    end
  endtask

  task automatic test_capture();
    logic [7:0] dvals [2];
    logic [7:0] pats [2];
    logic [7:0] e, g;
    dvals[0] = 8'h3C; pats[0] = 8'hFF;
    dvals[1] = 8'h1E; pats[1] = 8'h00;
    sel = 0; dmode = 1'b1;
    for (int t = 0; t < 2; t++) begin
      dconst = dvals[t];
      // chain[i] captures d[i]; unload puts chain[N-1] in result[0].
      exp_q.push_back(rev8(dvals[t]));
      st_cyc.push_back(0); st_pat.push_back(pats[t]);
      run_window(22);
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin
        errors++;
        $display("FAIL capture_result[%0d]: no done seen, want %h", t, e);
      end else begin
        g = got_q.pop_front();
        if (g !== e) begin
          errors++;
          $display("FAIL capture_result[%0d]: got %h want %h", t, g, e);
        end
      end
      checks++;
      if (se_tr[22:0] !== se_mask(8, 1)[22:0]) begin
        errors++;
        $display("FAIL capture_se[%0d]: got %b want %b", t, se_tr[22:0], se_mask(8, 1)[22:0]);
      end
    end
    dmode = 1'b0;
  endtask

  task automatic test_capt_sweep();
    logic [7:0] e, g;
    sel = 1;
    exp_q.push_back(8'h01);
    st_cyc.push_back(0); st_pat.push_back(8'h01);
    run_window(26);
    checks++;
    if (se_tr[26:0] !== se_mask(8, 3)[26:0]) begin
      errors++;
      $display("FAIL sweep_se: got %b want %b", se_tr[26:0], se_mask(8, 3)[26:0]);
    end
    checks++;
    if (done_cyc_q.size() != 1 || done_cyc_q[0] != 20) begin
      errors++;
      $display("FAIL sweep_done_cycle: got %0d dones first at %0d want one at 20",
               done_cyc_q.size(), (done_cyc_q.size() == 0) ? -1 : done_cyc_q[0]);
    end
    e = exp_q.pop_front();
    checks++;
    if (got_q.size() == 0) begin
      errors++;
      $display("FAIL sweep_result: no done seen, want %h", e);
    end else begin
      g = got_q.pop_front();
      if (g !== e) begin
        errors++;
        $display("FAIL sweep_result: got %h want %h", g, e);
      end
    end
  endtask

  task automatic test_busy_rejection();
    logic [7:0] e, g;
    sel = 0; dmode = 1'b0;
    // Starts at 5 (LOAD) and 18 (DONE) must be dropped; 19 is the first legal restart.
    st_cyc.push_back(0);  st_pat.push_back(8'hA5); exp_q.push_back(8'hA5);
    st_cyc.push_back(5);  st_pat.push_back(8'hFF);
    st_cyc.push_back(18); st_pat.push_back(8'hFF);
    st_cyc.push_back(19); st_pat.push_back(8'h3C); exp_q.push_back(8'h3C);
    run_window(45);
    checks++;
    if (done_cyc_q.size() != 2) begin
      errors++;
      $display("FAIL busy_done_count: got %0d want 2", done_cyc_q.size());
    end
    checks++;
    if (done_cyc_q.size() < 2 || done_cyc_q[0] != 18 || done_cyc_q[1] != 37) begin
      errors++;
      $display("FAIL busy_done_cycles: got %0d/%0d want 18/37",
               (done_cyc_q.size() > 0) ? done_cyc_q[0] : -1,
               (done_cyc_q.size() > 1) ? done_cyc_q[1] : -1);
    end
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin
        errors++;
        $display("FAIL busy_result[%0d]: no done seen, want %h", i, e);
      end else begin
        g = got_q.pop_front();
        if (g !== e) begin
          errors++;
          $display("FAIL busy_result[%0d]: got %h want %h", i, g, e);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] e, g;
    sel = 0; dmode = 1'b0;
    st_cyc.push_back(0); st_pat.push_back(8'hFF);
    rst_cyc = 4;
    st_cyc.push_back(8); st_pat.push_back(8'h5A); exp_q.push_back(8'h5A);
    run_window(32);
    checks++;
    if ({busy_tr[4], se_tr[5], busy_tr[5], si_tr[5]} !== 4'b1000) begin
      errors++;
      $display("FAIL midreset_ctrl: got %b want 1000",
               {busy_tr[4], se_tr[5], busy_tr[5], si_tr[5]});
    end
    checks++;
    if (res_tr[5] !== 8'h00) begin
      errors++;
      $display("FAIL midreset_result_clear: got %h want 00", res_tr[5]);
    end
    checks++;
    if (done_cyc_q.size() != 1 || done_cyc_q[0] != 26) begin
      errors++;
      $display("FAIL midreset_done: got %0d dones first at %0d want one at 26",
               done_cyc_q.size(), (done_cyc_q.size() == 0) ? -1 : done_cyc_q[0]);
    end
    e = exp_q.pop_front();
    checks++;
    if (got_q.size() == 0) begin
      errors++;
      $display("FAIL midreset_result: no done seen, want %h", e);
    end else begin
      g = got_q.pop_front();
      if (g !== e) begin
        errors++;
        $display("FAIL midreset_result: got %h want %h", g, e);
      end
    end
  endtask

  task automatic test_edge_size();
    logic [7:0] e, g;
    sel = 2;
    exp_q.push_back(8'h01);
    st_cyc.push_back(0); st_pat.push_back(8'h01);
    run_window(8);
    checks++;
    if (se_tr[8:0] !== se_mask(1, 1)[8:0]) begin
      errors++;
      $display("FAIL edge_se: got %b want %b", se_tr[8:0], se_mask(1, 1)[8:0]);
    end
    checks++;
    if (done_cyc_q.size() != 1 || done_cyc_q[0] != 4) begin
      errors++;
      $display("FAIL edge_done: got %0d dones first at %0d want one at 4",
               done_cyc_q.size(), (done_cyc_q.size() == 0) ? -1 : done_cyc_q[0]);
    end
    e = exp_q.pop_front();
    checks++;
    if (got_q.size() == 0) begin
      errors++;
      $display("FAIL edge_result: no done seen, want %h", e);
    end else begin
      g = got_q.pop_front();
      if (g !== e) begin
        errors++;
        $display("FAIL edge_result: got %h want %h", g, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_capture();
    test_capt_sweep();
    test_busy_rejection();
    test_mid_reset();
    test_edge_size();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
